// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame transmitter.
// State encoding, line levels and the even-parity function used by the checker.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Callers zero-extend narrower words; zero bits do not change the result.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Per-bit cycle counter: bit_tick is high in the last cycle of each serial bit.
// clr holds the count at zero so every frame starts on a fresh bit boundary.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start, data LSB first, supplied parity, stop.
// Flags words whose supplied parity disagrees with the data.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_bit,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic              parity_err
);

    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t          state_q, state_d;
    logic [DATA_W:0] sh_q, sh_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            tx_q, tx_d;
    logic            busy_q, ready_q, perr_q, perr_d;
    logic            bit_tick;
    logic            accept;

    assign accept = load_valid && ready_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == IDLE),
        .bit_tick(bit_tick)
    );

    // Parity rides in the top of the shift register, so it lands in bit 0
    // exactly when the last data bit has been shifted out.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    sh_d    = {parity_bit, data_in};
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    sh_d = sh_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx_out itself is a flop.
    always_comb begin
        tx_d = LINE_IDLE;
        unique case (state_d)
            START:       tx_d = START_BIT;
            DATA, PARITY: tx_d = sh_d[0];
            STOP:        tx_d = STOP_BIT;
            default:     tx_d = LINE_IDLE;
        endcase
        perr_d = accept && (even_parity(16'(data_in)) != parity_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == IDLE);
            perr_q  <= perr_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign load_ready = ready_q;
    assign parity_err = perr_q;
    assign frame_done = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: stimulus queues expected frames,
// a negedge monitor pops and checks every cycle of each observed frame.
module tb_parity_frame_tx;

    localparam int unsigned DW    = 4;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = (DW + 3) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          parity_bit = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready, tx_out, busy, frame_done, parity_err;

    always #5 clk = ~clk;

    parity_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .parity_bit(parity_bit),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .tx_out    (tx_out),
        .busy      (busy),
        .frame_done(frame_done),
        .parity_err(parity_err)
    );

    typedef struct packed {
        logic [0:6] seq;   // start, d0..d3, parity, stop in line order
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done) done_cnt++;
    end

    initial begin : monitor
        bit   in_frame;
        int   cyc;
        int   perr_seen;
        exp_t cur;
        in_frame  = 1'b0;
        cyc       = 0;
        perr_seen = 0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (busy && tx_out == 1'b0) begin
                        in_frame  = 1'b1;
                        cyc       = 1;
                        perr_seen = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", 32'd1, 32'd0);
                            cur = '0;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        chk("parity_err_slot", parity_err, cur.perr);
                    end
                end else begin
                    cyc++;
                end
                if (in_frame) begin
                    if (parity_err) perr_seen++;
                    if (cyc <= FRAME) begin
                        chk("tx_bit", tx_out, cur.seq[(cyc - 1) / CPB]);
                        chk("frame_done", frame_done, (cyc == FRAME));
                        chk("busy_in_frame", busy, 1'b1);
                    end
                    if (cyc == FRAME) chk("parity_err_count", perr_seen, cur.perr);
                    if (cyc == FRAME + 1) begin
                        chk("idle_gap_tx", tx_out, 1'b1);
                        chk("idle_gap_ready", load_ready, 1'b1);
                        chk("idle_gap_busy", busy, 1'b0);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves load_valid high; returns #1 after the accepting edge.
    task automatic send_accept(input logic [DW-1:0] d, input logic p);
        int t;
        data_in    = d;
        parity_bit = p;
        load_valid = 1'b1;
        t = 0;
        while (!load_ready && t < 200) begin
            step(1);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 32'd0, 32'd1);
        step(1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 400) begin
            step(1);
            t++;
        end
        if (t >= 400) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stimulus
        int d0;
        int t;

        rst = 1'b1;
        step(2);
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(1);

        exp_q.push_back('{seq: 7'b0010101, perr: 1'b0});
        send_accept(4'b1010, 1'b0);
        load_valid = 1'b0;
        wait_idle();

        exp_q.push_back('{seq: 7'b0101111, perr: 1'b0});
        send_accept(4'b1101, 1'b1);
        load_valid = 1'b0;
        wait_idle();

        exp_q.push_back('{seq: 7'b0100001, perr: 1'b1});
        send_accept(4'b0001, 1'b0);
        load_valid = 1'b0;
        wait_idle();

        // Mid-frame reset: monitor off, checks done inline.
        step(1);
        mon_en = 1'b0;
        send_accept(4'b1010, 1'b0);
        load_valid = 1'b0;
        step(9);
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_tx", tx_out, 1'b1);
        d0  = done_cnt;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_tx", tx_out, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", load_ready, 1'b1);
        chk("abort_done", frame_done, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (tx_out !== 1'b1 || busy !== 1'b0) chk("abort_idle_hold", {tx_out, busy}, 2'b10);
            step(1);
        end
        chk("abort_no_done", done_cnt, d0);
        mon_en = 1'b1;
        step(1);

        // load_valid held through the frame while data changes.
        exp_q.push_back('{seq: 7'b0110001, perr: 1'b0});
        exp_q.push_back('{seq: 7'b0001101, perr: 1'b0});
        send_accept(4'b0011, 1'b0);
        step(5);
        data_in    = 4'b1100;
        parity_bit = 1'b0;
        t = 0;
        while (!load_ready && t < 200) begin
            step(1);
            t++;
        end
        if (t >= 200) chk("second_ready_timeout", 32'd0, 32'd1);
        step(1);
        load_valid = 1'b0;
        wait_idle();
        step(3);

        chk("frame_done_total", done_cnt, 32'd5);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream consumer of the even parity generator. Accepts a data word plus its parity bit over a valid/ready handshake and serialises a framed line: start bit, data LSB first, parity, stop. Each bit is held for a programmable number of clock cycles. It also flags any word whose supplied parity does not match the data.

Parameters:
DATA_W, 4, data word width in bits (legal range 1 to 16).
CLKS_PER_BIT, 4, clock cycles each serial bit is held (legal range 1 or more).

Ports:
clk  input  1  single system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  DATA_W  word from the parity generator.
parity_bit  input  1  even parity bit from the generator; transmitted as supplied.
load_valid  input  1  upstream offers data_in and parity_bit.
load_ready  output  1  block can accept a word (high only in IDLE).
tx_out  output  1  serial line; idles high.
busy  output  1  high while a frame is in flight (any state other than IDLE).
frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.
parity_err  output  1  one-cycle pulse in the cycle after an accept whose (^data_in) != parity_bit.

Behaviour:
- Reset, sampled on the rising edge of clk:
  - state=IDLE; all counters cleared.
  - tx_out=1, busy=0, load_ready=1, frame_done=0, parity_err=0.
- Accept: occurs on an edge where load_valid && load_ready.
  - data_in and parity_bit are captured into a shift register.
  - After the accept edge, inputs have no further effect on the frame.
- States:
  - IDLE: tx_out=1; on accept -> START.
  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_out=captured bit i, i=0..DATA_W-1, LSB first, each held CLKS_PER_BIT cycles; after bit DATA_W-1 -> PARITY.
  - PARITY: tx_out=captured parity_bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles; frame_done=1 in the last cycle -> IDLE.
- Latency: tx_out falls in the cycle immediately after the accept edge.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles from that cycle to the end of the frame.
- Minimum idle gap: at least one IDLE cycle (tx_out=1) separates back-to-back frames; load_ready is low from the accept edge until IDLE is re-entered.
- load_valid while busy: ignored, and no capture takes place. Upstream holds its data until load_ready.
- parity_err: pulses only; it does not block transmission. The supplied parity_bit is still sent unchanged.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit advance. Width is $clog2(CLKS_PER_BIT) bits, minimum 1. With CLKS_PER_BIT=1 there is one cycle per bit and no dead cycles.
- Bit index counter: width is $clog2(DATA_W) bits, minimum 1; it wraps only on leaving DATA.
- Reset mid-frame:
  - The frame is aborted and the state returns to IDLE.
  - tx_out=1 from the next cycle.
  - No frame_done or parity_err is generated for the aborted frame.
- Simultaneous rst and load_valid: rst wins and nothing is captured.
- All outputs are registered; no combinational path from inputs to tx_out.

Decomposition:
- Shared package parity_pkg:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP.
  - line constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - helper function even_parity(word) for the check and for the bench.
- One natural sub-module: bit_timer. It is parameterised by CLKS_PER_BIT and takes inputs clk, rst, and clr. It outputs bit_tick, asserted in the last cycle of each bit.

Test Plan:
1. Assert rst for 2 cycles, then release -> tx_out=1, busy=0, load_ready=1, frame_done=0, parity_err=0.
2. DATA_W=4, CLKS_PER_BIT=4; accept data_in=4'b1010, parity_bit=0 -> tx_out bit sequence is 0,0,1,0,1,0,1 (start, d0..d3, parity, stop), each held 4 cycles. Expect 28 cycles total, frame_done in cycle 28 after the accept, parity_err never set.
3. Accept data_in=4'b1101, parity_bit=1 -> sequence 0,1,0,1,1,1,1; parity_err=0.
4. Accept data_in=4'b0001, parity_bit=0 (mismatch) -> parity_err pulses once in the cycle after the accept. The parity slot still carries 0 and the frame completes with frame_done.
5. Assert rst in cycle 10 of a frame (in DATA) -> IDLE, tx_out=1 from the next cycle. No frame_done; load_ready=1.
6. Hold load_valid high while busy and change data_in mid-frame from 4'b0011 to 4'b1100 -> the first frame transmits 0011 unaltered. After at least one idle cycle, the second frame sends 1100; exactly two frame_done pulses.
